// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Data has fixed priority; stall holds the pipeline until both accesses of the cycle are done.
//
// state  | meaning
// IDLE   | port free; pick the next pending access (data first)
// BUSY_D | data load/store in flight, waiting for mem_ready
// BUSY_I | instruction fetch in flight, waiting for mem_ready
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;
  logic              pend_d, pend_i;

  assign pend_d = dm_req & ~dm_done_q;
  assign pend_i = if_req & ~if_done_q;
  assign stall  = rst_n & (pend_d | pend_i);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = if_done_q;
    dm_done_d   = dm_done_q;

    // The pipeline advances on this edge, so the current cycle's done flags retire.
    if (!stall) begin
      if_done_d = 1'b0;
      dm_done_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (pend_d) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
        end else if (pend_i) begin
          state_d    = BUSY_I;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          dm_done_d = 1'b1;
          if (!mem_we_q) dm_rdata_d = mem_rdata;
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          if_done_d  = 1'b1;
          if_rdata_d = mem_rdata;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then random pipeline traffic checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, if_req, dm_req, dm_we, mem_ready;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_done, dm_done, stall, mem_req, mem_we;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int failures = 0;

  // inputs to present on the next cycle
  logic        nxt_rst_n, nxt_if_req, nxt_dm_req, nxt_dm_we;
  logic [31:0] nxt_if_addr, nxt_dm_addr, nxt_dm_wdata;

  // memory responder: 0 manual, 1 fixed wait count, 2 random
  int          resp_mode, resp_k, resp_cnt;
  logic        man_ready;
  logic [31:0] man_rdata, rd_i, rd_d;

  // transaction-level reference: one outstanding port transaction plus served flags
  logic        m_active, m_is_d, m_we, m_if_done, m_dm_done;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
  logic        exp_stall, adv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic pd, pi, started;
    started = 1'b0;
    if (!rst_n) begin
      m_active = 0; m_is_d = 0; m_we = 0; m_addr = 0; m_wdata = 0;
      m_if_rdata = 0; m_dm_rdata = 0; m_if_done = 0; m_dm_done = 0;
    end else begin
      pd = dm_req && !m_dm_done;
      pi = if_req && !m_if_done;
      if (!pd && !pi) begin
        m_if_done = 0;
        m_dm_done = 0;
      end
      if (m_active) begin
        if (mem_ready) begin
          m_active = 0;
          if (m_is_d) begin
            m_dm_done = 1;
            if (!m_we) m_dm_rdata = mem_rdata;
          end else begin
            m_if_done = 1;
            m_if_rdata = mem_rdata;
          end
        end
      end else if (pd) begin
        m_active = 1; m_is_d = 1; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
        started = 1;
      end else if (pi) begin
        m_active = 1; m_is_d = 0; m_we = 0; m_addr = if_addr;
        started = 1;
      end
    end
    if (started) resp_cnt = 0;
    else if (m_active) resp_cnt++;
  endtask

  task automatic apply_inputs();
    rst_n    = nxt_rst_n;
    if_req   = nxt_if_req;
    if_addr  = nxt_if_addr;
    dm_req   = nxt_dm_req;
    dm_we    = nxt_dm_we;
    dm_addr  = nxt_dm_addr;
    dm_wdata = nxt_dm_wdata;
    case (resp_mode)
      0: begin mem_ready = man_ready; mem_rdata = man_rdata; end
      1: begin
        mem_ready = m_active && (resp_cnt >= resp_k);
        mem_rdata = m_is_d ? rd_d : rd_i;
      end
      default: begin
        mem_ready = ($urandom_range(0, 99) < 40);
        mem_rdata = $urandom;
      end
    endcase
  endtask

  task automatic compare_model();
    exp_stall = rst_n && ((dm_req && !m_dm_done) || (if_req && !m_if_done));
    adv = !exp_stall;
    chk("stall", stall, exp_stall);
    chk("mem_req", mem_req, m_active);
    chk("mem_we", mem_we, m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("dm_rdata", dm_rdata, m_dm_rdata);
    chk("if_done", if_done, m_if_done);
    chk("dm_done", dm_done, m_dm_done);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    apply_inputs();
    @(negedge clk);
    compare_model();
  endtask

  task automatic clear_reqs();
    nxt_if_req = 0;
    nxt_dm_req = 0;
    nxt_dm_we  = 0;
  endtask

  task automatic run_instr(input logic ifr, input logic [31:0] ia, input logic dr, input logic we,
                           input logic [31:0] da, input logic [31:0] wd, input int k,
                           input logic [31:0] ri, input logic [31:0] rdd,
                           output int n_stall, output int n_req, output logic first_stall,
                           output logic [31:0] addr0, output logic [31:0] addr1, output logic held_ok);
    int   nrise, guard;
    logic prev_req;
    nxt_if_req = ifr; nxt_if_addr = ia;
    nxt_dm_req = dr; nxt_dm_we = we; nxt_dm_addr = da; nxt_dm_wdata = wd;
    resp_mode = 1; resp_k = k; rd_i = ri; rd_d = rdd;
    n_stall = 0; n_req = 0; nrise = 0; guard = 0; prev_req = 0; held_ok = 1;
    addr0 = '0; addr1 = '0; first_stall = 0;
    while (guard < 100) begin
      cycle();
      if (guard == 0) first_stall = stall;
      guard++;
      if (stall) n_stall++;
      if (mem_req) begin
        n_req++;
        if (!prev_req) begin
          if (nrise == 0) addr0 = mem_addr;
          else addr1 = mem_addr;
          nrise++;
        end
        if (dr && we && (mem_we !== 1'b1 || mem_wdata !== wd)) held_ok = 0;
      end
      prev_req = mem_req;
      if (stall !== 1'b1) break;
    end
    chk("run_bound_stall", stall, 0);
  endtask

  int          ns, nr;
  logic        fs, hk;
  logic [31:0] a0, a1;

  initial begin
    // reset with both requests and mem_ready asserted
    nxt_rst_n = 0; nxt_if_req = 1; nxt_if_addr = 32'h0040_0000;
    nxt_dm_req = 1; nxt_dm_we = 0; nxt_dm_addr = 32'h1000_0020; nxt_dm_wdata = 32'h5555_AAAA;
    resp_mode = 0; man_ready = 1; man_rdata = 32'hFFFF_0000; resp_k = 0; resp_cnt = 0;
    rd_i = 0; rd_d = 0;
    m_active = 0; m_is_d = 0; m_we = 0; m_addr = 0; m_wdata = 0;
    m_if_rdata = 0; m_dm_rdata = 0; m_if_done = 0; m_dm_done = 0;
    apply_inputs();
    repeat (2) begin
      cycle();
      chk("rst_stall", stall, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_dm_rdata", dm_rdata, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
    end
    nxt_rst_n = 1; man_ready = 0;
    cycle();
    chk("rel_idle_stall", stall, 1);
    chk("rel_idle_req", mem_req, 0);
    cycle();
    chk("rel_mem_req", mem_req, 1);
    chk("rel_mem_addr", mem_addr, 32'h1000_0020);
    chk("rel_mem_we", mem_we, 0);
    clear_reqs(); resp_mode = 1; resp_k = 0;
    repeat (4) cycle();

    // fetch, zero wait
    run_instr(1, 32'h0040_0000, 0, 0, 0, 0, 0, 32'h8C08_0004, 0, ns, nr, fs, a0, a1, hk);
    chk("f0_stall_cycles", ns, 2);
    chk("f0_req_cycles", nr, 1);
    chk("f0_addr", a0, 32'h0040_0000);
    chk("f0_if_rdata", if_rdata, 32'h8C08_0004);
    chk("f0_if_done", if_done, 1);
    clear_reqs();
    cycle();
    chk("f0_if_done_cleared", if_done, 0);

    // fetch + load, 3 wait cycles each
    run_instr(1, 32'h0040_0004, 1, 0, 32'h1000_0000, 0, 3, 32'h1111_2222, 32'h0000_00AA,
              ns, nr, fs, a0, a1, hk);
    chk("fl_stall_cycles", ns, 10);
    chk("fl_req_cycles", nr, 8);
    chk("fl_first_is_data", a0, 32'h1000_0000);
    chk("fl_second_is_fetch", a1, 32'h0040_0004);
    chk("fl_dm_rdata", dm_rdata, 32'h0000_00AA);
    chk("fl_if_rdata", if_rdata, 32'h1111_2222);
    clear_reqs();
    cycle();

    // load 0x12345678, then a store that must not touch dm_rdata
    run_instr(0, 0, 1, 0, 32'h1000_0004, 0, 0, 0, 32'h1234_5678, ns, nr, fs, a0, a1, hk);
    chk("ld_dm_rdata", dm_rdata, 32'h1234_5678);
    clear_reqs();
    cycle();
    run_instr(0, 0, 1, 1, 32'h1000_0010, 32'hDEAD_BEEF, 2, 0, 32'hFFFF_FFFF, ns, nr, fs, a0, a1, hk);
    chk("st_held", hk, 1);
    chk("st_req_cycles", nr, 3);
    chk("st_stall_cycles", ns, 4);
    chk("st_addr", a0, 32'h1000_0010);
    chk("st_dm_rdata_kept", dm_rdata, 32'h1234_5678);
    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    clear_reqs();
    cycle();

    // reset during the second wait cycle of a load
    nxt_dm_req = 1; nxt_dm_we = 0; nxt_dm_addr = 32'h1000_0020;
    resp_mode = 0; man_ready = 0; man_rdata = 32'hBAD0_BAD0;
    cycle();
    chk("mr_idle_stall", stall, 1);
    cycle();
    chk("mr_wait1_req", mem_req, 1);
    nxt_rst_n = 0;
    cycle();
    chk("mr_rst_stall", stall, 0);
    nxt_rst_n = 1; clear_reqs(); man_ready = 1;
    cycle();
    chk("mr_after_req", mem_req, 0);
    chk("mr_after_dm_done", dm_done, 0);
    chk("mr_after_dm_rdata", dm_rdata, 0);
    cycle();
    chk("mr_late_ready_req", mem_req, 0);
    chk("mr_late_ready_rdata", dm_rdata, 0);
    chk("mr_late_ready_done", dm_done, 0);
    man_ready = 0;

    // back-to-back fetches
    run_instr(1, 32'h0040_0000, 0, 0, 0, 0, 0, 32'h2008_0001, 0, ns, nr, fs, a0, a1, hk);
    chk("bb1_if_rdata", if_rdata, 32'h2008_0001);
    chk("bb1_req_cycles", nr, 1);
    run_instr(1, 32'h0040_0004, 0, 0, 0, 0, 0, 32'h2009_0002, 0, ns, nr, fs, a0, a1, hk);
    chk("bb2_gap_one_cycle", fs, 1);
    chk("bb2_req_cycles", nr, 1);
    chk("bb2_addr", a0, 32'h0040_0004);
    chk("bb2_if_rdata", if_rdata, 32'h2009_0002);
    clear_reqs();
    cycle();

    // random pipeline traffic
    resp_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      nxt_rst_n = ($urandom_range(0, 199) != 0);
      if (adv || $urandom_range(0, 29) == 0) begin
        nxt_if_req   = ($urandom_range(0, 3) != 0);
        nxt_if_addr  = $urandom;
        nxt_dm_req   = $urandom_range(0, 1);
        nxt_dm_we    = $urandom_range(0, 1);
        nxt_dm_addr  = $urandom;
        nxt_dm_wdata = $urandom;
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port of the MIPS pipeline between the IF stage (instruction fetch) and the MEM stage (load/store). Runs one transaction at a time through a small FSM, gives data accesses priority, and drives one global `stall` that freezes the pipeline until every pending access of the current cycle has completed. It sits between the pipeline registers and the external memory model. Its `dm_req`/`dm_we` inputs come from the MEM-stage copies of the main decoder's memory controls.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `if_req` in 1: fetch request, held until the pipeline advances
- `if_addr` in ADDR_W: fetch address (PC)
- `if_rdata` out DATA_W: fetched instruction, registered
- `if_done` out 1: fetch served for the current pipeline cycle
- `dm_req` in 1: data request (MemRead | MemWrite)
- `dm_we` in 1: 1 = store, 0 = load
- `dm_addr` in ADDR_W: ALU result address
- `dm_wdata` in DATA_W: store data
- `dm_rdata` out DATA_W: load data, registered
- `dm_done` out 1: data access served for the current pipeline cycle
- `stall` out 1: freeze PC and all pipeline registers
- `mem_req` out 1: port request, registered
- `mem_we` out 1: port write enable, registered
- `mem_addr` out ADDR_W: port address, registered
- `mem_wdata` out DATA_W: port write data, registered
- `mem_ready` in 1: transaction completes this cycle; `mem_rdata` is valid
- `mem_rdata` in DATA_W: port read data

## Operation
- FSM states: IDLE, BUSY_D, BUSY_I.
- Pending flags:
  - `pend_d = dm_req & ~dm_done`
  - `pend_i = if_req & ~if_done`
- `stall = pend_d | pend_i`. This output is combinational and is forced to 0 while `rst_n = 0`.
- In IDLE:
  - `pend_d` → BUSY_D. Latch `dm_addr`, `dm_wdata` and `dm_we` into the `mem_*` outputs and set `mem_req = 1`.
  - Otherwise `pend_i` → BUSY_I. Latch `if_addr`, set `mem_we = 0` and `mem_req = 1`.
  - Data has fixed priority. Both accesses must finish before the pipeline advances, so fetch cannot starve.
- In BUSY_x, `mem_*` outputs are held stable until `mem_ready = 1`. At that edge:
  - State → IDLE and `mem_req` → 0.
  - The matching `x_done` flag is set.
  - For BUSY_I, `if_rdata ← mem_rdata`. For a BUSY_D load, `dm_rdata ← mem_rdata`.
  - For a BUSY_D store, `dm_rdata` is unchanged.
- There is always one IDLE cycle between transactions. BUSY_D never goes directly to BUSY_I.
- Advance: on any edge with `stall = 0`, clear `if_done` and `dm_done`. The pipeline moves on that same edge, so new requests are evaluated from the next cycle.
- A request that drops while its access is in flight is not aborted. The access completes and its data is captured. The done flag clears on the next advance.
- `mem_ready` while in IDLE is ignored.
- Reset (`rst_n = 0` at an edge, including mid-transaction):
  - State → IDLE.
  - `mem_req`, `mem_we`, `if_done`, `dm_done` → 0.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata` → 0.
  - Any in-flight memory transaction is abandoned. The memory must tolerate `mem_req` dropping.

## Timing
- A request is seen in IDLE at cycle n. `mem_req` is high from n+1.
- With k wait cycles, `mem_ready` is high at cycle n+1+k.
- `x_done` and the read data are visible at n+2+k. `stall` drops at n+2+k if nothing else is pending.
- Single access, zero wait: `stall` is high for 2 cycles.
- Fetch + data, zero wait:
  - `mem_req` is high at n+1 (data) and again at n+3 (fetch).
  - `stall` is high for cycles n..n+3 and low at n+4.
- `mem_req` is never high for two different transactions in consecutive cycles.
- Read data outputs hold their value until the next completion of the same kind, or until reset.

## Test plan
- Reset:
  - Stimulus: `rst_n = 0` for 2 cycles with `if_req = dm_req = 1` and `mem_ready = 1`.
  - Response: `stall = 0`, `mem_req = 0`, all data outputs 0. After release, `mem_req = 1` with `mem_we` and `mem_addr` taken from `dm_*` one cycle later.
- Fetch, zero wait:
  - Stimulus: `if_req = 1`, `if_addr = 0x0040_0000`; `mem_ready = 1` on the first `mem_req` cycle with `mem_rdata = 0x8C08_0004`.
  - Response: `mem_req` high for exactly 1 cycle, `if_rdata = 0x8C08_0004`, `stall` high for 2 cycles, `if_done` cleared on the advance edge.
- Fetch + load, 3 wait cycles each:
  - Stimulus: fetch at `0x0040_0004`; load from `dm_addr = 0x1000_0000` returning `0x0000_00AA`.
  - Response: data transaction first, one IDLE bubble, then fetch. `dm_rdata = 0x0000_00AA`. `stall` high for 10 cycles.
- Store:
  - Stimulus: `dm_we = 1`, `dm_addr = 0x1000_0010`, `dm_wdata = 0xDEAD_BEEF`, with `dm_rdata` previously `0x1234_5678`.
  - Response: `mem_we = 1`, `mem_wdata = 0xDEAD_BEEF` held through the wait cycles. `dm_rdata` stays `0x1234_5678`.
- Reset mid-transaction:
  - Stimulus: `rst_n = 0` during the second wait cycle of a load.
  - Response: next cycle, `mem_req = 0`, state IDLE, `dm_done = 0`. A late `mem_ready` in IDLE is ignored.
- Back-to-back instructions:
  - Stimulus: `if_req` held high across two advances with addresses `0x0040_0000` then `0x0040_0004`.
  - Response: two separate `mem_req` transactions, `stall` low for exactly 1 cycle between them, `if_rdata` updates per fetch.
